// File: rtl/axi_lite_reg_slave_if.sv
// AXI4-Lite bus bundle between a master adapter and the register slave.
interface axi_lite_reg_slave_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] S_AXI_AWADDR;
  logic              S_AXI_AWVALID;
  logic              S_AXI_AWREADY;
  logic [31:0]       S_AXI_WDATA;
  logic [3:0]        S_AXI_WSTRB;
  logic              S_AXI_WVALID;
  logic              S_AXI_WREADY;
  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID;
  logic              S_AXI_BREADY;
  logic [ADDR_W-1:0] S_AXI_ARADDR;
  logic              S_AXI_ARVALID;
  logic              S_AXI_ARREADY;
  logic [31:0]       S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RVALID;
  logic              S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register bank: NUM_REGS x 32-bit control/status registers with
// byte-strobed writes, one-hot write pulses and SLVERR on out-of-range access.
module axi_lite_reg_slave #(
  parameter int ADDR_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  axi_lite_reg_slave_if.slave      s_axi,
  output logic [32*NUM_REGS-1:0]   reg_q,
  output logic [NUM_REGS-1:0]      wr_pulse
);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [31:0]       regs [NUM_REGS];
  logic              aw_held, w_held;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [31:0]       w_data_q;
  logic [3:0]        w_strb_q;
  logic              bvalid_q, rvalid_q;
  logic [1:0]        bresp_q, rresp_q;
  logic [31:0]       rdata_q;

  logic              aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              wr_in_range, rd_in_range;
  logic [NUM_REGS-1:0] wr_onehot;

  assign s_axi.S_AXI_AWREADY = !aw_held && !bvalid_q;
  assign s_axi.S_AXI_WREADY  = !w_held && !bvalid_q;
  assign s_axi.S_AXI_ARREADY = !rvalid_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;

  assign aw_hs = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
  assign w_hs  = s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY;
  assign ar_hs = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;

  // A write commits as soon as address and data are both available, whether
  // captured earlier or arriving this cycle; the live bus wins over an empty latch.
  assign commit  = (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_addr = aw_held ? aw_addr_q : s_axi.S_AXI_AWADDR;
  assign wr_data = w_held ? w_data_q : s_axi.S_AXI_WDATA;
  assign wr_strb = w_held ? w_strb_q : s_axi.S_AXI_WSTRB;

  assign wr_idx      = wr_addr[2 +: IDX_W];
  assign wr_in_range = (wr_addr >> (IDX_W + 2)) == '0;
  assign rd_idx      = s_axi.S_AXI_ARADDR[2 +: IDX_W];
  assign rd_in_range = (s_axi.S_AXI_ARADDR >> (IDX_W + 2)) == '0;

  always_comb begin
    wr_onehot         = '0;
    wr_onehot[wr_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      wr_pulse  <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else begin
      wr_pulse <= '0;
      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        if (wr_in_range) begin
          bresp_q  <= RESP_OKAY;
          wr_pulse <= wr_onehot;
          for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end else begin
          bresp_q <= RESP_SLVERR;
        end
      end else begin
        if (aw_hs) begin
          aw_held   <= 1'b1;
          aw_addr_q <= s_axi.S_AXI_AWADDR;
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= s_axi.S_AXI_WDATA;
          w_strb_q <= s_axi.S_AXI_WSTRB;
        end
        if (bvalid_q && s_axi.S_AXI_BREADY) bvalid_q <= 1'b0;
      end
    end
  end

  // Reads sample regs as they stood before this edge, so a same-edge write is not visible.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rresp_q  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
      rdata_q  <= rd_in_range ? regs[rd_idx] : 32'h0;
    end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_q
    assign reg_q[32*k +: 32] = regs[k];
  end
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave: stimulus pushes expected B/R responses
// into queues that an independent monitor pops whenever the DUT presents them.
module tb_axi_lite_reg_slave;
  localparam int ADDR_W   = 32;
  localparam int NUM_REGS = 16;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef struct {
    logic [1:0]          resp;
    logic [NUM_REGS-1:0] pulse;
  } b_item_t;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
  } r_item_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [32*NUM_REGS-1:0] reg_q;
  logic [NUM_REGS-1:0]    wr_pulse;

  int checks = 0;
  int failures = 0;
  b_item_t b_q[$];
  r_item_t r_q[$];
  logic bvalid_prev = 1'b0;

  axi_lite_reg_slave_if #(.ADDR_W(ADDR_W)) bus ();

  axi_lite_reg_slave #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .s_axi   (bus),
    .reg_q   (reg_q),
    .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic flag_timeout(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s timeout waiting for handshake", name);
  endtask

  function automatic logic [31:0] get_reg(input int k);
    return reg_q[32*k +: 32];
  endfunction

  // Monitor: every presented response is compared against the head of its queue.
  always @(negedge clk) begin
    if (!resetn) begin
      bvalid_prev = 1'b0;
    end else begin
      if (bus.S_AXI_BVALID) begin
        if (b_q.size() == 0) begin
          flag_timeout("unexpected_bvalid");
        end else begin
          if (!bvalid_prev) check_output("wr_pulse", 64'(wr_pulse), 64'(b_q[0].pulse));
          check_output("bresp", 64'(bus.S_AXI_BRESP), 64'(b_q[0].resp));
          if (bus.S_AXI_BREADY) void'(b_q.pop_front());
        end
      end
      if (!(bus.S_AXI_BVALID && !bvalid_prev)) check_output("wr_pulse_idle", 64'(wr_pulse), 64'h0);
      bvalid_prev = bus.S_AXI_BVALID;
      if (bus.S_AXI_RVALID) begin
        if (r_q.size() == 0) begin
          flag_timeout("unexpected_rvalid");
        end else begin
          check_output("rresp", 64'(bus.S_AXI_RRESP), 64'(r_q[0].resp));
          check_output("rdata", 64'(bus.S_AXI_RDATA), 64'(r_q[0].data));
          if (bus.S_AXI_RREADY) void'(r_q.pop_front());
        end
      end
    end
  end

  task automatic send_aw(input logic [31:0] addr);
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_AWVALID = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.S_AXI_AWREADY) begin
        @(posedge clk);
        #1 bus.S_AXI_AWVALID = 1'b0;
        return;
      end
    end
    bus.S_AXI_AWVALID = 1'b0;
    flag_timeout("aw_handshake");
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
    bus.S_AXI_WDATA  = data;
    bus.S_AXI_WSTRB  = strb;
    bus.S_AXI_WVALID = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.S_AXI_WREADY) begin
        @(posedge clk);
        #1 bus.S_AXI_WVALID = 1'b0;
        return;
      end
    end
    bus.S_AXI_WVALID = 1'b0;
    flag_timeout("w_handshake");
  endtask

  task automatic send_ar(input logic [31:0] addr);
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.S_AXI_ARREADY) begin
        @(posedge clk);
        #1 bus.S_AXI_ARVALID = 1'b0;
        return;
      end
    end
    bus.S_AXI_ARVALID = 1'b0;
    flag_timeout("ar_handshake");
  endtask

  task automatic apply_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [1:0] resp, input logic [NUM_REGS-1:0] pulse);
    b_q.push_back('{resp: resp, pulse: pulse});
    fork
      send_aw(addr);
      send_w(data, strb);
    join
  endtask

  task automatic apply_read(input logic [31:0] addr, input logic [1:0] resp, input logic [31:0] data);
    r_q.push_back('{resp: resp, data: data});
    send_ar(addr);
  endtask

  task automatic wait_drain(input string name);
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      #2;
      if (b_q.size() == 0 && r_q.size() == 0) return;
    end
    flag_timeout(name);
    b_q.delete();
    r_q.delete();
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    @(negedge clk);
    check_output("rst_awready", 64'(bus.S_AXI_AWREADY), 64'h1);
    check_output("rst_wready", 64'(bus.S_AXI_WREADY), 64'h1);
    check_output("rst_arready", 64'(bus.S_AXI_ARREADY), 64'h1);
    check_output("rst_bvalid", 64'(bus.S_AXI_BVALID), 64'h0);
    check_output("rst_rvalid", 64'(bus.S_AXI_RVALID), 64'h0);
    check_output("rst_regs_zero", 64'(reg_q == '0), 64'h1);

    // AW and W together
    @(posedge clk); #1;
    apply_write(32'h8, 32'hDEADBEEF, 4'hF, OKAY, 16'h0004);
    wait_drain("drain_w_together");
    check_output("reg2", 64'(get_reg(2)), 64'hDEADBEEF);

    // W three cycles ahead of AW
    b_q.push_back('{resp: OKAY, pulse: 16'h0002});
    send_w(32'h12345678, 4'hF);
    @(negedge clk);
    check_output("wready_after_w_capture", 64'(bus.S_AXI_WREADY), 64'h0);
    check_output("no_commit_without_aw", 64'(bus.S_AXI_BVALID), 64'h0);
    repeat (2) @(posedge clk);
    #1 send_aw(32'h4);
    @(negedge clk);
    check_output("bvalid_after_aw", 64'(bus.S_AXI_BVALID), 64'h1);
    wait_drain("drain_w_first");
    check_output("reg1", 64'(get_reg(1)), 64'h12345678);

    // Partial writes and zero strobe
    apply_write(32'h0C, 32'hFFFFFFFF, 4'hF, OKAY, 16'h0008);
    apply_write(32'h0C, 32'h00000000, 4'b0101, OKAY, 16'h0008);
    wait_drain("drain_partial");
    check_output("reg3_partial", 64'(get_reg(3)), 64'hFF00FF00);
    apply_read(32'h0E, OKAY, 32'hFF00FF00);
    apply_write(32'h4, 32'h00000000, 4'h0, OKAY, 16'h0002);
    wait_drain("drain_strb0");
    check_output("reg1_strb0", 64'(get_reg(1)), 64'h12345678);

    // Same-edge read and write of reg1: read sees the old value
    fork
      apply_write(32'h4, 32'hCAFEF00D, 4'hF, OKAY, 16'h0002);
      apply_read(32'h4, OKAY, 32'h12345678);
    join
    wait_drain("drain_collision");
    check_output("reg1_after_collision", 64'(get_reg(1)), 64'hCAFEF00D);

    // Out of range
    apply_write(32'h40, 32'h11111111, 4'hF, SLVERR, 16'h0000);
    apply_read(32'h40, SLVERR, 32'h0);
    wait_drain("drain_oor");
    check_output("oor_reg0", 64'(get_reg(0)), 64'h0);
    check_output("oor_reg2", 64'(get_reg(2)), 64'hDEADBEEF);

    // Backpressure on B then R
    bus.S_AXI_BREADY = 1'b0;
    apply_write(32'h14, 32'hA5A5A5A5, 4'hF, OKAY, 16'h0020);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("bp_bvalid", 64'(bus.S_AXI_BVALID), 64'h1);
      check_output("bp_awready", 64'(bus.S_AXI_AWREADY), 64'h0);
      check_output("bp_wready", 64'(bus.S_AXI_WREADY), 64'h0);
    end
    @(posedge clk); #1 bus.S_AXI_BREADY = 1'b1;
    wait_drain("drain_bp_b");
    bus.S_AXI_RREADY = 1'b0;
    apply_read(32'h14, OKAY, 32'hA5A5A5A5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("bp_rvalid", 64'(bus.S_AXI_RVALID), 64'h1);
      check_output("bp_arready", 64'(bus.S_AXI_ARREADY), 64'h0);
    end
    @(posedge clk); #1 bus.S_AXI_RREADY = 1'b1;
    wait_drain("drain_bp_r");

    // Reset with AW captured but W still missing
    send_aw(32'h18);
    apply_reset();
    @(negedge clk);
    check_output("rst2_bvalid", 64'(bus.S_AXI_BVALID), 64'h0);
    check_output("rst2_regs_zero", 64'(reg_q == '0), 64'h1);
    check_output("rst2_awready", 64'(bus.S_AXI_AWREADY), 64'h1);
    check_output("rst2_wready", 64'(bus.S_AXI_WREADY), 64'h1);
    check_output("rst2_arready", 64'(bus.S_AXI_ARREADY), 64'h1);
    @(posedge clk); #1;
    send_w(32'h0BADF00D, 4'hF);
    repeat (3) @(negedge clk);
    check_output("no_stale_commit", 64'(bus.S_AXI_BVALID), 64'h0);
    check_output("w_held_after_reset", 64'(bus.S_AXI_WREADY), 64'h0);
    b_q.push_back('{resp: OKAY, pulse: 16'h0001});
    @(posedge clk); #1;
    send_aw(32'h0);
    wait_drain("drain_after_reset");
    check_output("reg0_after_reset", 64'(get_reg(0)), 64'h0BADF00D);
    check_output("reg6_untouched", 64'(get_reg(6)), 64'h0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
